// File: rtl/diff_vector_decoder.sv
// diff_vector_decoder
//   Rebuilds a WIDTH-bit vector v from its cyclic neighbour-XOR difference
//   vector d plus the seed bit v[0]. The decode is a serial prefix-XOR that
//   produces LANES bits per clock: v[i] = v[i-1] ^ d[i-1].
//   d[WIDTH-1] (the wrap term) is never used to rebuild v. It only feeds the
//   frame parity: out_err = ^d, which is 1 when the wrap term is inconsistent.
//
//   Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both 1. A producer holds valid and its data until
//   that edge. in_ready is 1 only in IDLE, and is forced low while reset is
//   high. out_valid, out_vec and out_err are held stable in DONE until the
//   transfer edge.
//
//   Optional feature: define DIFF_DEC_ERRCNT_EN to add err_count[7:0], a
//   saturating count of delivered frames with out_err=1.
//
//   state_dbg exposes the FSM state (0=IDLE, 1=RUN, 2=DONE).
module diff_vector_decoder #(
  parameter int WIDTH = 100,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_diff,
  input  logic             in_seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
  output logic             out_err,
`ifdef DIFF_DEC_ERRCNT_EN
  output logic [7:0]       err_count,
`endif
  output logic [1:0]       state_dbg
);

  // Wide enough to hold idx + LANES without wrapping.
  localparam int IDXW = $clog2(WIDTH + LANES) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-2:0] d_q;      // d[WIDTH-1] only matters for parity, not kept
  logic [IDXW-1:0]  idx;      // next bit of v to reconstruct
  logic [IDXW-1:0]  idx_end;  // one past the last bit handled this cycle
  logic [WIDTH-1:0] run_vec;  // out_vec after this cycle's lanes

  assign in_ready  = (state == IDLE) && !reset;
  assign state_dbg = state;
  assign idx_end   = idx + IDXW'(LANES);

  // Chain up to LANES prefix-XOR steps over the window [idx, idx+LANES).
  always_comb begin
    run_vec = out_vec;
    for (int j = 1; j < WIDTH; j++) begin
      if ((IDXW'(j) >= idx) && (IDXW'(j) < idx_end)) begin
        run_vec[j] = run_vec[j-1] ^ d_q[j-1];
      end
    end
  end

  // Frame FSM: accept in IDLE, decode in RUN, hold the result in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_err   <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_q     <= in_diff[WIDTH-2:0];
            out_vec <= {{(WIDTH-1){1'b0}}, in_seed};
            out_err <= ^in_diff;
            idx     <= IDXW'(1);
            state   <= RUN;
          end
        end
        RUN: begin
          out_vec <= run_vec;
          idx     <= idx_end;
          if (idx_end >= IDXW'(WIDTH)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIFF_DEC_ERRCNT_EN
  // Count delivered frames whose wrap parity was bad; stick at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if ((state == DONE) && out_ready && out_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_diff_vector_decoder.sv
// tb_diff_vector_decoder
//   Directed table of frames on the default (LANES=4) instance, DONE-stall
//   and mid-frame reset sequences, plus LANES=1 / LANES=99 instances
//   checked against a prefix-XOR reference.
module tb_diff_vector_decoder;

  localparam int W = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // default instance signals
  logic         in_valid, in_ready, in_seed, out_valid, out_ready, out_err;
  logic [W-1:0] in_diff, out_vec;
  logic [1:0]   state_dbg;

  // shared stimulus for the LANES=1 / LANES=99 instances
  logic         in_valid_a, in_seed_a, out_ready_a;
  logic [W-1:0] in_diff_a;
  logic         ir1, ov1, err1, ir99, ov99, err99;
  logic [W-1:0] vec1, vec99;
  logic [1:0]   st1, st99;

`ifdef DIFF_DEC_ERRCNT_EN
  logic [7:0] err_count, err_count1, err_count99;
`endif

  diff_vector_decoder #(.WIDTH(W), .LANES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_diff(in_diff), .in_seed(in_seed), .out_valid(out_valid),
    .out_ready(out_ready), .out_vec(out_vec), .out_err(out_err),
`ifdef DIFF_DEC_ERRCNT_EN
    .err_count(err_count),
`endif
    .state_dbg(state_dbg)
  );

  diff_vector_decoder #(.WIDTH(W), .LANES(1)) dut_l1 (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(ir1),
    .in_diff(in_diff_a), .in_seed(in_seed_a), .out_valid(ov1),
    .out_ready(out_ready_a), .out_vec(vec1), .out_err(err1),
`ifdef DIFF_DEC_ERRCNT_EN
    .err_count(err_count1),
`endif
    .state_dbg(st1)
  );

  diff_vector_decoder #(.WIDTH(W), .LANES(99)) dut_l99 (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(ir99),
    .in_diff(in_diff_a), .in_seed(in_seed_a), .out_valid(ov99),
    .out_ready(out_ready_a), .out_vec(vec99), .out_err(err99),
`ifdef DIFF_DEC_ERRCNT_EN
    .err_count(err_count99),
`endif
    .state_dbg(st99)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int exp_errcnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_main(input logic [W-1:0] diff, input logic seed);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", W'(in_ready), W'(1'b1));
    in_diff  = diff;
    in_seed  = seed;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_main(input string name, input logic [W-1:0] ev, input logic ee);
    int lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, "_latency"}, W'(lat), W'(25));
    check({name, "_vec"}, out_vec, ev);
    check({name, "_err"}, W'(out_err), W'(ee));
    check({name, "_busy"}, W'(in_ready), W'(1'b0));
  endtask

  task automatic handshake_main(input string name);
    logic e;
    e = out_err;
    out_ready = 1'b1;
    @(posedge clk);
    if (e && exp_errcnt < 255) exp_errcnt++;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_drop"}, W'(out_valid), W'(1'b0));
    check({name, "_ready_back"}, W'(in_ready), W'(1'b1));
`ifdef DIFF_DEC_ERRCNT_EN
    check({name, "_errcnt"}, W'(err_count), W'(exp_errcnt));
`endif
  endtask

  task automatic run_aux(input logic [W-1:0] diff, input logic seed);
    logic [W-1:0] ev;
    logic ee, acc;
    bit got1, got99;
    int lat, t;
    // reference: v[i] = seed ^ d[0] ^ ... ^ d[i-1]
    acc = seed;
    ev[0] = seed;
    for (int i = 1; i < W; i++) begin
      acc = acc ^ diff[i-1];
      ev[i] = acc;
    end
    ee = 1'b0;
    for (int i = 0; i < W; i++) ee = ee ^ diff[i];
    exp_q.push_back(ev);
    t = 0;
    while (!(ir1 && ir99) && t < 100) begin
      @(negedge clk);
      t++;
    end
    in_diff_a  = diff;
    in_seed_a  = seed;
    in_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    ev = exp_q.pop_front();
    got1 = 0;
    got99 = 0;
    lat = 0;
    while (!(got1 && got99) && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ov1 && !got1) begin
        got1 = 1;
        check("l1_latency", W'(lat), W'(99));
        check("l1_vec", vec1, ev);
        check("l1_err", W'(err1), W'(ee));
      end
      if (ov99 && !got99) begin
        got99 = 1;
        check("l99_latency", W'(lat), W'(1));
        check("l99_vec", vec99, ev);
        check("l99_err", W'(err99), W'(ee));
      end
    end
    check("aux_done", W'(got1 && got99), W'(1'b1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    logic         seed;
    logic [W-1:0] diff;
    logic [W-1:0] vec;
    logic         err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [W-1:0] hold_vec;
    logic         hold_err;

    tbl[0] = '{"zero",      1'b0, '0,                    '0,             1'b0};
    tbl[1] = '{"ones",      1'b1, '0,                    '1,             1'b0};
    tbl[2] = '{"alt",       1'b1, '1,                    {50{2'b01}},    1'b0};
    tbl[3] = '{"d0",        1'b0, W'(1),                 ~W'(1),         1'b1};
    tbl[4] = '{"d1",        1'b0, W'(2),                 ~W'(3),         1'b1};
    tbl[5] = '{"wrap_only", 1'b1, {1'b1, 99'b0},         '1,             1'b1};
    tbl[6] = '{"wrap_d0",   1'b0, {1'b1, 98'b0, 1'b1},   ~W'(1),         1'b0};

    reset       = 1'b1;
    in_valid    = 1'b0;
    in_diff     = '0;
    in_seed     = 1'b0;
    out_ready   = 1'b0;
    in_valid_a  = 1'b0;
    in_diff_a   = '0;
    in_seed_a   = 1'b0;
    out_ready_a = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(1'b0));
    check("rst_out_valid", W'(out_valid), W'(1'b0));
    check("rst_out_vec", out_vec, '0);
    check("rst_out_err", W'(out_err), W'(1'b0));
    check("rst_state", W'(state_dbg), W'(2'd0));
    reset = 1'b0;
    #1;
    check("rst_release_ready", W'(in_ready), W'(1'b1));
    @(negedge clk);

    // table-driven frames
    for (int k = 0; k < 7; k++) begin
      send_main(tbl[k].diff, tbl[k].seed);
      wait_main(tbl[k].name, tbl[k].vec, tbl[k].err);
      handshake_main(tbl[k].name);
    end

    // DONE stall: result held, new data on the input ignored
    send_main(tbl[3].diff, tbl[3].seed);
    wait_main("stall", tbl[3].vec, tbl[3].err);
    hold_vec = out_vec;
    hold_err = out_err;
    in_diff  = '1;
    in_seed  = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_vec", out_vec, tbl[3].vec);
      check("stall_err", W'(out_err), W'(tbl[3].err));
      check("stall_valid", W'(out_valid), W'(1'b1));
      check("stall_in_ready", W'(in_ready), W'(1'b0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    if (hold_err && exp_errcnt < 255) exp_errcnt++;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_release_valid", W'(out_valid), W'(1'b0));
    check("stall_release_ready", W'(in_ready), W'(1'b1));
    check("stall_vec_kept", out_vec, hold_vec);
`ifdef DIFF_DEC_ERRCNT_EN
    check("stall_errcnt", W'(err_count), W'(exp_errcnt));
`endif
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_main("after_stall", tbl[2].vec, tbl[2].err);
    handshake_main("after_stall");

    // reset on RUN edge 12 aborts the frame
    send_main(tbl[1].diff, tbl[1].seed);
    repeat (11) @(negedge clk);
    check("pre_abort_state", W'(state_dbg), W'(2'd1));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_valid", W'(out_valid), W'(1'b0));
    check("abort_vec", out_vec, '0);
    check("abort_in_ready", W'(in_ready), W'(1'b0));
    check("abort_state", W'(state_dbg), W'(2'd0));
    reset = 1'b0;
    exp_errcnt = 0;
    #1;
    check("abort_release_ready", W'(in_ready), W'(1'b1));
`ifdef DIFF_DEC_ERRCNT_EN
    check("abort_errcnt", W'(err_count), W'(0));
`endif
    @(negedge clk);
    send_main(tbl[2].diff, tbl[2].seed);
    wait_main("post_abort", tbl[2].vec, tbl[2].err);
    handshake_main("post_abort");

    // LANES=1 and LANES=99 against the reference
    run_aux(tbl[3].diff, 1'b0);
    run_aux({1'b1, 98'b0, 1'b1}, 1'b1);
    for (int r = 0; r < 4; r++) begin
      run_aux(W'({$urandom, $urandom, $urandom, $urandom}), 1'($urandom_range(0, 1)));
    end

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
